// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment scan controller.
// Scan FSM state encoding and segment bus bit positions.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  localparam int unsigned SEG_DP_BIT = 7;

endpackage

// File: rtl/scan_divider.sv
// Digit slot counter: counts 0..REFRESH_DIV-1 while run_i is high.
// Ports: clk/rst_n, run_i (count enable, clears when low), show_end_o, tc_o.
module scan_divider #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic show_end_o,
  output logic tc_o
);

  localparam int unsigned W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] TC =
    W'(REFRESH_DIV - 1);
  localparam logic [W-1:0] SE =
    W'(REFRESH_DIV - BLANK_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o       = (cnt_q == TC);
  assign show_end_o = (cnt_q == SE);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (!run_i || tc_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexes one external 7-seg decoder across DIGITS common-anode digits.
// Ports: load/load_ready frame handshake, dec_* decoder link, seg_out/anode_n pins.
module seven_segment_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  decimal_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            dec_value,
  output logic                  dec_decimal,
  input  logic [7:0]            dec_segments,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     anode_n
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [4*DIGITS-1:0] shadow_val_q, staged_val_q;
  logic [DIGITS-1:0]   shadow_dp_q, staged_dp_q;
  logic                shadow_dec_q, staged_dec_q;
  logic                pending_q;

  logic [DIGITS-1:0] anode_q, anode_d;
  logic [7:0]        seg_q, seg_d;

  logic run, show_end, tc, wrap;
  logic accept, commit, lit;
  logic [3:0] digit_w [DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign digit_w[k] = shadow_val_q[4*k +: 4];
  end

  // Divider only runs inside a slot; IDLE and disable hold it at 0.
  assign run = enable && (state_q != IDLE);

  scan_divider #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run),
    .show_end_o (show_end),
    .tc_o       (tc)
  );

  assign wrap = enable && (state_q == BLANK)
             && tc && (idx_q == LAST);

  assign load_ready = !pending_q;
  assign accept     = load && !pending_q;
  // accept needs !pending and commit needs pending,
  // so a wrap-cycle load waits for the next wrap.
  assign commit     = pending_q
                   && (wrap || state_q == IDLE);

  assign dec_value   = digit_w[idx_q];
  assign dec_decimal = shadow_dec_q;
  assign seg_out     = seg_q;
  assign anode_n     = anode_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (enable) state_d = SHOW;
      end
      SHOW: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (show_end) begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tc) begin
          state_d = SHOW;
          idx_d   = (idx_q == LAST)
                  ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Pins go dark on the same edge enable drops.
  assign lit = enable && (state_q == SHOW);

  always_comb begin
    anode_d = '1;
    seg_d   = '0;
    if (lit) begin
      anode_d[idx_q]    = 1'b0;
      seg_d             = dec_segments;
      seg_d[SEG_DP_BIT] = shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged_val_q <= '0;
      staged_dp_q  <= '0;
      staged_dec_q <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_dec_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      if (accept) begin
        staged_val_q <= value_in;
        staged_dp_q  <= dp_in;
        staged_dec_q <= decimal_in;
        pending_q    <= 1'b1;
      end else if (commit) begin
        shadow_val_q <= staged_val_q;
        shadow_dp_q  <= staged_dp_q;
        shadow_dec_q <= staged_dec_q;
        pending_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller (DIGITS=4, REFRESH_DIV=8, BLANK=2).
// A decoder model closes the dec_* loop; a monitor scores pin changes.
module tb_seven_segment_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic        load_ready;
  logic [15:0] value_in;
  logic        decimal_in;
  logic [3:0]  dp_in;
  logic [3:0]  dec_value;
  logic        dec_decimal;
  logic [7:0]  dec_segments;
  logic [7:0]  seg_out;
  logic [3:0]  anode_n;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       dec;
    int         len;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  // Hex font; decimal mode shows a dash above 9.
  // Bit 7 follows the mode so the dp override is visible.
  function automatic logic [7:0] decode(
    input logic [3:0] v, input logic m);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h3F;  4'h1: f = 7'h06;
      4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
      4'h4: f = 7'h66;  4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;  4'h7: f = 7'h07;
      4'h8: f = 7'h7F;  4'h9: f = 7'h6F;
      4'hA: f = 7'h77;  4'hB: f = 7'h7C;
      4'hC: f = 7'h39;  4'hD: f = 7'h5E;
      4'hE: f = 7'h79;  default: f = 7'h71;
    endcase
    if (m && v > 4'd9) f = 7'h40;
    return {m, f};
  endfunction

  always_comb dec_segments = decode(dec_value, dec_decimal);

  seven_segment_scan_controller #(
    .DIGITS       (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .load         (load),
    .load_ready   (load_ready),
    .value_in     (value_in),
    .decimal_in   (decimal_in),
    .dp_in        (dp_in),
    .dec_value    (dec_value),
    .dec_decimal  (dec_decimal),
    .dec_segments (dec_segments),
    .seg_out      (seg_out),
    .anode_n      (anode_n)
  );

  task automatic check(input string name,
    input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] an,
    input logic [7:0] seg, input logic dec,
    input int len);
    exp_t e;
    e.an = an; e.seg = seg;
    e.dec = dec; e.len = len;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] s0,
    input logic [7:0] s1, input logic [7:0] s2,
    input logic [7:0] s3, input logic dec);
    push(4'b1110, s0, dec, 6); push(4'hF, 8'h0, dec, 2);
    push(4'b1101, s1, dec, 6); push(4'hF, 8'h0, dec, 2);
    push(4'b1011, s2, dec, 6); push(4'hF, 8'h0, dec, 2);
    push(4'b0111, s3, dec, 6); push(4'hF, 8'h0, dec, 2);
  endtask

  // Waits for a fresh transition of anode_n into p.
  task automatic wait_change(input logic [3:0] p,
    input string name);
    logic [3:0] pv;
    int t;
    pv = anode_n;
    t  = 0;
    forever begin
      @(negedge clk);
      if (anode_n == p && pv != p) break;
      pv = anode_n;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting anode_n=%b",
                 name, p);
        break;
      end
    end
  endtask

  // Monitor: every change on the pins pops one record.
  initial begin : monitor
    logic [11:0] prev;
    exp_t cur;
    bit have;
    int run;
    prev = 12'hF00;
    have = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if ({anode_n, seg_out} !== prev) begin
        if (have && cur.len != 0)
          check("slot_len", run, cur.len);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          have = 1'b0;
          $display("FAIL unexpected_event: got %b/%h",
                   anode_n, seg_out);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          check("anode_n", anode_n, cur.an);
          check("seg_out", seg_out, cur.seg);
          check("dec_decimal", dec_decimal, cur.dec);
        end
        prev = {anode_n, seg_out};
        run  = 1;
      end else begin
        run++;
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    value_in   = '0;
    decimal_in = 1'b0;
    dp_in      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_anode", anode_n, 4'hF);
      check("rst_seg", seg_out, 8'h00);
      check("rst_ready", load_ready, 1'b1);
    end
    check("rst_dec_value", dec_value, 4'h0);

    value_in = 16'h4321;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("idle_load_busy", load_ready, 1'b0);
    @(negedge clk);
    check("idle_commit_ready", load_ready, 1'b1);

    push_frame(8'h06, 8'h5B, 8'h4F, 8'h66, 1'b0);
    push_frame(8'h6D, 8'h7D, 8'h07, 8'h7F, 1'b0);
    enable = 1'b1;

    wait_change(4'b1101, "f1_d1");
    value_in = 16'h8765;
    load     = 1'b1;
    @(negedge clk);
    check("mid_load_busy", load_ready, 1'b0);
    value_in = 16'hFFFF;
    @(negedge clk);
    load = 1'b0;
    check("bp_still_busy", load_ready, 1'b0);

    wait_change(4'b1110, "f2_d0");
    check("wrap_ready", load_ready, 1'b1);

    wait_change(4'b1101, "f2_d1");
    value_in   = 16'h5A21;
    dp_in      = 4'b0100;
    decimal_in = 1'b1;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("f3_load_busy", load_ready, 1'b0);
    push(4'b1110, 8'h06, 1'b1, 6); push(4'hF, 8'h0, 1'b1, 2);
    push(4'b1101, 8'h5B, 1'b1, 6); push(4'hF, 8'h0, 1'b1, 2);
    push(4'b1011, 8'hC0, 1'b1, 0);
    push(4'hF, 8'h0, 1'b1, 0);

    wait_change(4'b1011, "f2_d2");
    wait_change(4'b1011, "f3_d2");
    check("dp_on", seg_out[7], 1'b1);
    check("mode_on", dec_decimal, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_anode", anode_n, 4'hF);
    check("disable_seg", seg_out, 8'h00);

    repeat (3) @(negedge clk);
    push(4'b1110, 8'h06, 1'b1, 6); push(4'hF, 8'h0, 1'b1, 2);
    push(4'b1101, 8'h5B, 1'b1, 0);
    push(4'hF, 8'h0, 1'b0, 0);
    enable = 1'b1;
    wait_change(4'b1110, "reen_d0");
    wait_change(4'b1101, "reen_d1");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_anode", anode_n, 4'hF);
    check("async_seg", seg_out, 8'h00);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", load_ready, 1'b1);
    check("post_rst_value", dec_value, 4'h0);
    check("post_rst_mode", dec_decimal, 1'b0);
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
